// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and default constants for the reset sequencer
// Purpose: FSM state encoding and default timing constants used by reset_sequencer.
// Ports: none (package).
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_STAGGER = 2'd1,
    ST_RUN     = 2'd2
  } seq_state_t;

  localparam int DEF_HOLD_CYCLES     = 1_000_000;
  localparam int DEF_NUM_CH          = 4;
  localparam int DEF_STAGGER_CYCLES  = 16;
  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 8;

endpackage

// File: rtl/reset_sync.sv
// rtl/reset_sync.sv - asynchronous-assert, synchronous-deassert reset synchroniser
// Purpose: rst_s_o goes high immediately with rst_i and falls on the
//          SYNC_STAGES-th rising clock edge after rst_i falls.
// Ports:
//   clk_i    - clock
//   rst_i    - asynchronous active-high reset in
//   rst_s_o  - synchronised active-high reset out
module reset_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic rst_s_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
    end
  end

  assign rst_s_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staggered multi-channel reset release sequencer
// Purpose: holds NUM_CH active-low reset domains for HOLD_CYCLES after reset
//          (or an accepted software request), then releases them one by one,
//          STAGGER_CYCLES apart, starting with bit 0.
// Optional: define RESET_SEQ_SWREQ_FILTER_EN to qualify sw_req over
//           DEBOUNCE_CYCLES consecutive high samples (one accept per high period).
// Ports:
//   clock      - system clock
//   reset      - asynchronous active-high reset
//   sw_req     - synchronous software restart request
//   reset_n    - per-channel active-low reset, bit 0 released first
//   all_ready  - high once every channel is released
//   seq_state  - current state: 0 HOLD, 1 STAGGER, 2 RUN
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sw_req,
  output logic [NUM_CH-1:0] reset_n,
  output logic              all_ready,
  output logic [1:0]        seq_state
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int STAG_W = $clog2(STAGGER_CYCLES + 1);
  localparam int CH_W   = $clog2(NUM_CH + 1);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [STAG_W-1:0] STAG_LAST = STAG_W'(STAGGER_CYCLES - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NUM_CH - 1);

  logic rst_s;
  logic sw_accept;

  seq_state_t        state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [STAG_W-1:0] stag_cnt_q;
  logic [CH_W-1:0]   ch_idx_q;
  logic [NUM_CH-1:0] reset_n_q;
  logic              all_ready_q;

  // rst_s asserts combinationally with reset (async set inside the
  // synchroniser), so every flop below drops immediately on reset.
  reset_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_reset_sync (
    .clk_i  (clock),
    .rst_i  (reset),
    .rst_s_o(rst_s)
  );

`ifdef RESET_SEQ_SWREQ_FILTER_EN
  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             fired_q, fired_d;

  // deb_cnt counts earlier consecutive high samples; the DEBOUNCE_CYCLES-th
  // high sample accepts, then fired blocks further accepts until sw_req drops.
  always_comb begin
    deb_cnt_d = deb_cnt_q;
    fired_d   = fired_q;
    sw_accept = 1'b0;
    if (!sw_req) begin
      deb_cnt_d = '0;
      fired_d   = 1'b0;
    end else if (!fired_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        sw_accept = 1'b1;
        fired_d   = 1'b1;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge rst_s) begin
    if (rst_s) begin
      deb_cnt_q <= '0;
      fired_q   <= 1'b0;
    end else begin
      deb_cnt_q <= deb_cnt_d;
      fired_q   <= fired_d;
    end
  end
`else
  logic unused_debounce;
  assign unused_debounce = (DEBOUNCE_CYCLES != 0);
  assign sw_accept = sw_req;
`endif

  always_ff @(posedge clock or posedge rst_s) begin
    if (rst_s) begin
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      ch_idx_q    <= '0;
      reset_n_q   <= '0;
      all_ready_q <= 1'b0;
    end else if (sw_accept) begin
      // The accept edge plays the role of t0 for the rerun.
      state_q     <= ST_HOLD;
      hold_cnt_q  <= '0;
      stag_cnt_q  <= '0;
      ch_idx_q    <= '0;
      reset_n_q   <= '0;
      all_ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_q    <= ST_STAGGER;
            hold_cnt_q <= '0;
            stag_cnt_q <= '0;
            ch_idx_q   <= '0;
            reset_n_q  <= NUM_CH'(1);
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        ST_STAGGER: begin
          if (ch_idx_q == CH_LAST) begin
            // Last channel went out on the previous edge.
            state_q     <= ST_RUN;
            stag_cnt_q  <= '0;
            ch_idx_q    <= '0;
            all_ready_q <= 1'b1;
          end else if (stag_cnt_q == STAG_LAST) begin
            // Released bits are contiguous from bit 0, so shifting a 1 in
            // sets reset_n[ch_idx+1] without a variable index.
            stag_cnt_q <= '0;
            ch_idx_q   <= ch_idx_q + 1'b1;
            reset_n_q  <= NUM_CH'({reset_n_q, 1'b1});
          end else begin
            stag_cnt_q <= stag_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          reset_n_q   <= '1;
          all_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_HOLD;
          hold_cnt_q  <= '0;
          stag_cnt_q  <= '0;
          ch_idx_q    <= '0;
          reset_n_q   <= '0;
          all_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign reset_n   = reset_n_q;
  assign all_ready = all_ready_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed table-driven bench for reset_sequencer
module tb_reset_sequencer;

  localparam int HOLD_CYCLES     = 10;
  localparam int NUM_CH          = 3;
  localparam int STAGGER_CYCLES  = 4;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 8;

  logic              clock;
  logic              reset;
  logic              sw_req;
  logic [NUM_CH-1:0] reset_n;
  logic              all_ready;
  logic [1:0]        seq_state;

  int checks;
  int failures;

  reset_sequencer #(
    .HOLD_CYCLES    (HOLD_CYCLES),
    .NUM_CH         (NUM_CH),
    .STAGGER_CYCLES (STAGGER_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .sw_req   (sw_req),
    .reset_n  (reset_n),
    .all_ready(all_ready),
    .seq_state(seq_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int         off;
    logic [2:0] rn;
    logic       rdy;
    logic [1:0] st;
  } vec_t;

  localparam int NVEC = 10;
  vec_t tbl [NVEC];

  // Passes exactly one rising edge and returns at the following falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string name, input logic [2:0] rn,
                       input logic rdy, input logic [1:0] st);
    checks++;
    if (reset_n !== rn || all_ready !== rdy || seq_state !== st) begin
      failures++;
      $display("FAIL %s: got reset_n=%b all_ready=%b seq_state=%0d, want reset_n=%b all_ready=%b seq_state=%0d",
               name, reset_n, all_ready, seq_state, rn, rdy, st);
    end
  endtask

  // Caller must be at the falling edge just after t0 (offset 0).
  task automatic run_table(input string tag);
    int cur;
    cur = 0;
    for (int i = 0; i < NVEC; i++) begin
      while (cur < tbl[i].off) begin
        tick();
        cur++;
      end
      check($sformatf("%s_t0+%0d", tag, tbl[i].off), tbl[i].rn, tbl[i].rdy, tbl[i].st);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    // Expected timeline from t0: bit k at t0+10+4k, all_ready one edge after bit 2.
    tbl[0] = '{off: 0,  rn: 3'b000, rdy: 1'b0, st: 2'd0};
    tbl[1] = '{off: 1,  rn: 3'b000, rdy: 1'b0, st: 2'd0};
    tbl[2] = '{off: 9,  rn: 3'b000, rdy: 1'b0, st: 2'd0};
    tbl[3] = '{off: 10, rn: 3'b001, rdy: 1'b0, st: 2'd1};
    tbl[4] = '{off: 13, rn: 3'b001, rdy: 1'b0, st: 2'd1};
    tbl[5] = '{off: 14, rn: 3'b011, rdy: 1'b0, st: 2'd1};
    tbl[6] = '{off: 17, rn: 3'b011, rdy: 1'b0, st: 2'd1};
    tbl[7] = '{off: 18, rn: 3'b111, rdy: 1'b0, st: 2'd1};
    tbl[8] = '{off: 19, rn: 3'b111, rdy: 1'b1, st: 2'd2};
    tbl[9] = '{off: 22, rn: 3'b111, rdy: 1'b1, st: 2'd2};

    // Power-up
    reset  = 1'b1;
    sw_req = 1'b0;
    tick();
    check("por_in_reset", 3'b000, 1'b0, 2'd0);
    repeat (3) tick();
    check("por_hold", 3'b000, 1'b0, 2'd0);
    reset = 1'b0;
    tick();
    check("por_sync_edge1", 3'b000, 1'b0, 2'd0);
    tick();
    run_table("pwrup");

    // Async assert in RUN, no clock edge between raise and check
    #2 reset = 1'b1;
    #1 check("async_assert", 3'b000, 1'b0, 2'd0);
    tick();
    check("async_held", 3'b000, 1'b0, 2'd0);
    reset = 1'b0;
    repeat (2) tick();
    run_table("rerst");

    // One-cycle sw_req in RUN: accept edge acts as t0
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    run_table("swrun");

    // sw_req mid-STAGGER just after bit0 released
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    repeat (10) tick();
    check("stag_bit0_up", 3'b001, 1'b0, 2'd1);
    sw_req = 1'b1;
    tick();
    sw_req = 1'b0;
    run_table("swstag");

    // sw_req held high for 25 cycles
    sw_req = 1'b1;
    for (int i = 0; i < 25; i++) begin
      tick();
      check($sformatf("held_%0d", i), 3'b000, 1'b0, 2'd0);
    end
    sw_req = 1'b0;
    run_table("swheld");

`ifdef RESET_SEQ_SWREQ_FILTER_EN
    // 7-cycle pulse ignored
    sw_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("filt7_%0d", i), 3'b111, 1'b1, 2'd2);
    end
    sw_req = 1'b0;
    repeat (2) tick();
    check("filt7_after", 3'b111, 1'b1, 2'd2);

    // 8th consecutive high sample accepts; extra high cycles do not restart
    sw_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("filt8_pre_%0d", i), 3'b111, 1'b1, 2'd2);
    end
    tick();
    check("filt8_accept", 3'b000, 1'b0, 2'd0);
    repeat (4) tick();
    check("filt8_still_hold", 3'b000, 1'b0, 2'd0);
    sw_req = 1'b0;
    repeat (6) tick();
    check("filt8_bit0_once", 3'b001, 1'b0, 2'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
